// File: rtl/sync_fifo_flagged_if.sv
// Handshake, data and status bundle for sync_fifo_flagged.
// master = producer/consumer side, slave = FIFO side.
interface sync_fifo_flagged_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO of arbitrary depth with count, almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle read.
module sync_fifo_flagged #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input logic               clk,
  input logic               arst,
  sync_fifo_flagged_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] AF_LVL = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL = CW'(AE_THRESH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_nxt;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic             wr_acc, rd_acc;

  // Explicit wrap keeps non power-of-2 depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_acc    = bus.rd_en & ~empty_q;
    wr_acc    = bus.wr_en & (~full_q | rd_acc);
    count_nxt = count_q;
    if (wr_acc && !rd_acc)
      count_nxt = count_q + CW'(1);
    else if (rd_acc && !wr_acc)
      count_nxt = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_nxt;
      full_q  <= (count_nxt == FULL_LVL);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_LVL);
      ae_q    <= (count_nxt <= AE_LVL);
      // A new error event in the same cycle as clr_err keeps the flag set.
      if (bus.wr_en && full_q && !rd_acc) ovf_q <= 1'b1;
      else if (bus.clr_err)               ovf_q <= 1'b0;
      if (bus.rd_en && empty_q)           unf_q <= 1'b1;
      else if (bus.clr_err)               unf_q <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = empty_q ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] dout_q;

  // Nonblocking read of the head gives read-before-write when full.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      dout_q <= '0;
    else if (rd_acc)
      dout_q <= mem[rd_ptr];
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench for sync_fifo_flagged (WIDTH=8, DEPTH=8, AF=6, AE=2).
// Flag vector order: {full, empty, almost_full, almost_empty, overflow, underflow}.
module tb_sync_fifo_flagged;
  logic clk = 1'b0;
  logic arst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sync_fifo_flagged_if #(.WIDTH(8), .DEPTH(8)) fifo_bus ();

  sync_fifo_flagged #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (fifo_bus)
  );

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    logic [3:0] cnt;
    logic [5:0] flags;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic rd, logic clr, logic [7:0] din,
                              logic [3:0] cnt, logic [5:0] flags, logic [7:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.cnt = cnt; v.flags = flags; v.dout = dout;
    return v;
  endfunction

  function automatic logic [5:0] cur_flags();
    return {fifo_bus.full, fifo_bus.empty, fifo_bus.almost_full,
            fifo_bus.almost_empty, fifo_bus.overflow, fifo_bus.underflow};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifo_bus.wr_en = 0; fifo_bus.rd_en = 0; fifo_bus.clr_err = 0; fifo_bus.data_in = '0;
  endtask

  task automatic do_reset();
    idle();
    arst = 1;
    #3;
    step();
    arst = 0;
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_bus.wr_en = 1; fifo_bus.data_in = d;
    step();
    idle();
  endtask

  // Pop one word and check it: before the edge in FWFT mode, after it in registered mode.
  task automatic pop_check(input string nm, input logic [7:0] exp, input logic also_wr,
                           input logic [7:0] wdata);
`ifdef FIFO_FWFT_EN
    check(nm, 32'(fifo_bus.data_out), 32'(exp));
`endif
    fifo_bus.rd_en = 1; fifo_bus.wr_en = also_wr; fifo_bus.data_in = wdata;
    step();
    idle();
`ifndef FIFO_FWFT_EN
    check(nm, 32'(fifo_bus.data_out), 32'(exp));
`endif
  endtask

  initial begin
    arst = 1;
    idle();

    // Table: idle, fill 8, overflow, drain 8, underflow, clear, set-wins, empty wr+rd.
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'd0, 6'b010100, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h01, 4'd1, 6'b000100, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h02, 4'd2, 6'b000100, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h03, 4'd3, 6'b000000, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h04, 4'd4, 6'b000000, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h05, 4'd5, 6'b000000, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h06, 4'd6, 6'b001000, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h07, 4'd7, 6'b001000, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h08, 4'd8, 6'b101000, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'hFF, 4'd8, 6'b101010, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4'd7, 6'b001010, 8'h01));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4'd6, 6'b001010, 8'h02));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4'd5, 6'b000010, 8'h03));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4'd4, 6'b000010, 8'h04));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4'd3, 6'b000010, 8'h05));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4'd2, 6'b000110, 8'h06));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4'd1, 6'b000110, 8'h07));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4'd0, 6'b010110, 8'h08));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4'd0, 6'b010111, 8'h08));
    vecs.push_back(mk(0, 0, 1, 8'h00, 4'd0, 6'b010100, 8'h08));
    vecs.push_back(mk(0, 1, 1, 8'h00, 4'd0, 6'b010101, 8'h08));
    vecs.push_back(mk(0, 0, 1, 8'h00, 4'd0, 6'b010100, 8'h08));
    vecs.push_back(mk(1, 1, 0, 8'h77, 4'd1, 6'b000101, 8'h08));
    vecs.push_back(mk(0, 1, 1, 8'h00, 4'd0, 6'b010100, 8'h77));

    // Reset state, checked while reset is held.
    #2;
    check("rst_count", 32'(fifo_bus.count), 32'd0);
    check("rst_flags", 32'(cur_flags()), 32'b010100);
    check("rst_dout",  32'(fifo_bus.data_out), 32'd0);
    do_reset();

    foreach (vecs[i]) begin
      fifo_bus.wr_en = vecs[i].wr; fifo_bus.rd_en = vecs[i].rd;
      fifo_bus.clr_err = vecs[i].clr; fifo_bus.data_in = vecs[i].din;
      step();
      check($sformatf("vec%0d_count", i), 32'(fifo_bus.count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_flags", i), 32'(cur_flags()), 32'(vecs[i].flags));
`ifndef FIFO_FWFT_EN
      check($sformatf("vec%0d_dout", i), 32'(fifo_bus.data_out), 32'(vecs[i].dout));
`endif
    end
    idle();

    // Full with simultaneous write and read: old head comes out, 0xAA lands at the tail.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    check("full_cnt", 32'(fifo_bus.count), 32'd8);
    pop_check("full_wr_rd_head", 8'h10, 1'b1, 8'hAA);
    check("full_wr_rd_cnt",   32'(fifo_bus.count), 32'd8);
    check("full_wr_rd_flags", 32'(cur_flags()), 32'b101000);
    for (int i = 1; i < 8; i++) pop_check($sformatf("full_drain%0d", i), 8'(8'h10 + i), 1'b0, 8'h00);
    pop_check("full_drain_aa", 8'hAA, 1'b0, 8'h00);
    check("full_drain_cnt", 32'(fifo_bus.count), 32'd0);

    // Streaming with 3 outstanding: 20 words, pointers wrap twice.
    do_reset();
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 17; i++) begin
      pop_check($sformatf("stream%0d", i), 8'(8'h30 + i), 1'b1, 8'(8'h33 + i));
      check($sformatf("stream%0d_cnt", i), 32'(fifo_bus.count), 32'd3);
    end
    for (int i = 17; i < 20; i++) pop_check($sformatf("stream%0d", i), 8'(8'h30 + i), 1'b0, 8'h00);
    check("stream_end_flags", 32'(cur_flags()), 32'b010100);

    // Asynchronous reset mid-stream with count 5 and a sticky underflow.
    do_reset();
    fifo_bus.rd_en = 1;
    step();
    idle();
    for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
    pop_check("mid_pop", 8'h50, 1'b0, 8'h00);
    check("mid_cnt",   32'(fifo_bus.count), 32'd5);
    check("mid_flags", 32'(cur_flags()), 32'b000001);
    #2;
    arst = 1;
    #1;
    check("arst_cnt",   32'(fifo_bus.count), 32'd0);
    check("arst_flags", 32'(cur_flags()), 32'b010100);
    check("arst_dout",  32'(fifo_bus.data_out), 32'd0);
    #10;
    arst = 0;
    #2;

`ifdef FIFO_FWFT_EN
    do_reset();
    push(8'h5A);
    check("fwft_show", 32'(fifo_bus.data_out), 32'h5A);
    check("fwft_nonempty", 32'(fifo_bus.empty), 32'd0);
    fifo_bus.rd_en = 1;
    step();
    idle();
    check("fwft_pop_empty", 32'(fifo_bus.empty), 32'd1);
    check("fwft_pop_dout",  32'(fifo_bus.data_out), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
